mfp_eic_input_conditioner: RTL

//  Per-channel conditioning of raw, asynchronous interrupt lines before they reach the EIC.

---
 rtl/mfp_eic_input_conditioner_pkg.sv | 26 ++
 rtl/mfp_eic_filter_channel.sv | 93 +++++++++
 rtl/mfp_eic_input_conditioner.sv | 63 ++++++
 3 files changed

// File: rtl/mfp_eic_input_conditioner_pkg.sv
// Purpose : shared defaults and helpers for the EIC input conditioner.
// Latency : n/a (package only).
// Backpressure: n/a; the conditioner has no flow control, it samples every cycle.
package mfp_eic_input_conditioner_pkg;

    // Number of interrupt lines presented to the EIC.
    localparam int EIC_CHANNELS         = 4;

    // Synchronizer depth per line; two flops is the minimum for metastability settling.
    localparam int EIC_COND_SYNC_STAGES = 2;

    // Consecutive stable cycles (seen at the synchronizer output) before a new level is accepted.
    localparam int EIC_COND_FILTER_LEN  = 8;

    // Width of the per-channel stability counter. The counter only has to reach
    // FILTER_LEN-1, and is kept at least one bit wide so FILTER_LEN=1 still elaborates.
    function automatic int cond_cnt_width(input int filter_len);
        int w;
        w = $clog2(filter_len);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mfp_eic_filter_channel.sv
// Purpose : one interrupt line: synchronizer chain, glitch filter, registered edge flags.
// Latency : SYNC_STAGES+FILTER_LEN cycles filtered, SYNC_STAGES+1 bypassed; edges one cycle after filt_out.
// Backpressure: none; a new sample is taken every clock.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   raw_in   - raw (possibly pre-inverted) interrupt level, asynchronous to clk
//   bypass   - 1 = copy the synchronized level straight to filt_out
//   filt_out - filtered level
//   rise     - one-cycle pulse the cycle after filt_out goes 0->1
//   fall     - one-cycle pulse the cycle after filt_out goes 1->0
module mfp_eic_filter_channel
    import mfp_eic_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = EIC_COND_SYNC_STAGES,
    parameter int FILTER_LEN  = EIC_COND_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    input  logic bypass,
    output logic filt_out,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cond_cnt_width(FILTER_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic                   filt_q,     filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic                   rise_q,     rise_d;
    logic                   fall_q,     fall_d;

    logic                   sync_lvl;

    // Last synchronizer stage is the only point where the line is considered clean.
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        // Shift the raw level into the synchronizer; stage 0 is the only flop
        // that ever sees the asynchronous input.
        sync_d     = {sync_q[SYNC_STAGES-2:0], raw_in};

        cnt_d      = '0;
        filt_d     = filt_q;

        if (bypass) begin
            // Counter stays cleared so leaving bypass restarts qualification
            // from whatever level filt_out currently holds.
            filt_d = sync_lvl;
        end else if (sync_lvl != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_lvl;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
        // sync_lvl == filt_q: any partial count is a rejected glitch, cnt_d stays 0.

        // Edge flags compare filt_out with its own previous value, so they
        // trail the level change by one cycle and can never both be set.
        filt_dly_d = filt_q;
        rise_d     = filt_q & ~filt_dly_q;
        fall_d     = ~filt_q & filt_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign filt_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/mfp_eic_input_conditioner.sv
// Purpose : conditions CHANNELS raw interrupt lines (sync, glitch filter, edge flags) ahead of the EIC.
// Latency : SYNC_STAGES+FILTER_LEN cycles per filtered line, SYNC_STAGES+1 when bypassed.
// Backpressure: none; every line is sampled every clock.
//
// Optional feature macro: MFP_EIC_COND_POLARITY_EN
//   defined   - adds the polarity port; raw_in ^ polarity enters the synchronizer,
//               so active-low sources are presented active-high.
//   undefined - no polarity port; raw_in is used as-is.
//
// Ports:
//   CLK      - system clock (same as EIC HCLK)
//   RESETn   - asynchronous active-low reset
//   raw_in   - raw interrupt lines, asynchronous to CLK
//   bypass   - per-line filter bypass (static or quasi-static)
//   polarity - per-line inversion, 1 = active-low source (macro builds only)
//   filt_out - filtered levels, connect to EIC_input
//   rise     - per-line one-cycle pulse after filt_out goes 0->1
//   fall     - per-line one-cycle pulse after filt_out goes 1->0
module mfp_eic_input_conditioner
    import mfp_eic_input_conditioner_pkg::*;
#(
    parameter int CHANNELS    = EIC_CHANNELS,
    parameter int SYNC_STAGES = EIC_COND_SYNC_STAGES,
    parameter int FILTER_LEN  = EIC_COND_FILTER_LEN
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] bypass,
`ifdef MFP_EIC_COND_POLARITY_EN
    input  logic [CHANNELS-1:0] polarity,
`endif
    output logic [CHANNELS-1:0] filt_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    logic [CHANNELS-1:0] raw_eff;

`ifdef MFP_EIC_COND_POLARITY_EN
    // Inversion sits ahead of the first sync flop, so a static active-low
    // line is seen as idle (0) from reset onwards.
    assign raw_eff = raw_in ^ polarity;
`else
    assign raw_eff = raw_in;
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        mfp_eic_filter_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk      (CLK),
            .rst_n    (RESETn),
            .raw_in   (raw_eff[ch]),
            .bypass   (bypass[ch]),
            .filt_out (filt_out[ch]),
            .rise     (rise[ch]),
            .fall     (fall[ch])
        );
    end

endmodule
